// File: rtl/mem_access_unit_pkg.sv
// Shared types for the data-memory access unit.
// MAU_ALIGN_CHECK_EN turns misaligned half/word requests into errors.
package mem_access_unit_pkg;

  localparam int ADDR = 16;
  localparam int WORD = 32;
  localparam int LEN  = WORD / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_ERR
  } state_e;

  typedef struct packed {
    logic            we;
    size_e           size;
    logic            sgn;
    logic [1:0]      off;
    logic [WORD-1:0] wdata;
  } req_t;

  // Without the alignment check, stray low offset bits are dropped.
  function automatic logic [1:0] eff_off(size_e s, logic [1:0] o);
    logic [1:0] r;
    r = o;
    unique case (1'b1)
      (s == SZ_HALF): r = {o[1], 1'b0};
      (s == SZ_WORD): r = 2'b00;
      default:        r = o;
    endcase
    return r;
  endfunction

  function automatic logic size_err(size_e s, logic [1:0] o);
    logic e;
`ifdef MAU_ALIGN_CHECK_EN
    e = (s == SZ_RSVD)
      | ((s == SZ_HALF) & o[0])
      | ((s == SZ_WORD) & (o != 2'b00));
`else
    e = (s == SZ_RSVD) & (o == o);
`endif
    return e;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus single-port memory bus.
// master = execute side and memory, slave = the access unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_w;
  logic [WORD_W-1:0] mem_d;
  logic [WORD_W-1:0] mem_q;

  modport master (
    output req_valid, req_we, req_size,
    output req_signed, req_addr, req_wdata,
    output mem_q,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, mem_a, mem_w, mem_d
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_signed, req_addr, req_wdata,
    input  mem_q,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, mem_a, mem_w, mem_d
  );

endinterface

// File: rtl/mem_access_unit_lane.sv
// Little-endian lane extract/extend for loads and
// read-modify-write merge for sub-word stores.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [WORD-1:0]        word_i,
  input  logic [$clog2(LEN)-1:0] off_i,
  input  size_e                  size_i,
  input  logic                   sgn_i,
  input  logic [WORD-1:0]        data_i,
  output logic [WORD-1:0]        load_o,
  output logic [WORD-1:0]        merge_o
);

  logic [4:0]      sh;
  logic [WORD-1:0] lane;
  logic [WORD-1:0] mask;

  assign sh   = {off_i, 3'b000};
  assign lane = word_i >> sh;

  always_comb begin
    load_o = word_i;
    mask   = '1;
    unique case (1'b1)
      (size_i == SZ_BYTE): begin
        load_o = {{24{sgn_i & lane[7]}}, lane[7:0]};
        mask   = 32'h0000_00ff;
      end
      (size_i == SZ_HALF): begin
        load_o = {{16{sgn_i & lane[15]}}, lane[15:0]};
        mask   = 32'h0000_ffff;
      end
      default: begin
        load_o = word_i;
        mask   = '1;
      end
    endcase
    merge_o = (word_i & ~(mask << sh))
            | ((data_i & mask) << sh);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: byte/half/word loads and stores,
// sub-word stores via read-modify-write on a word-only memory.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR,
  parameter int WORD_W = WORD
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_w_q, mem_w_d;
  logic [WORD_W-1:0] mem_d_q, mem_d_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              rerr_q, rerr_d;

  size_e             in_size;
  logic [1:0]        in_off;
  logic [WORD_W-1:0] load_w;
  logic [WORD_W-1:0] merge_w;

  assign in_size = size_e'(bus.req_size);
  assign in_off  = bus.req_addr[1:0];

  mem_lane_align u_lane (
    .word_i  (bus.mem_q),
    .off_i   (req_q.off),
    .size_i  (req_q.size),
    .sgn_i   (req_q.sgn),
    .data_i  (req_q.wdata),
    .load_o  (load_w),
    .merge_o (merge_w)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    mem_a_d  = mem_a_q;
    mem_w_d  = 1'b0;
    mem_d_d  = mem_d_q;
    rdata_d  = '0;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d.we    = bus.req_we;
          req_d.size  = in_size;
          req_d.sgn   = bus.req_signed;
          req_d.off   = eff_off(in_size, in_off);
          req_d.wdata = bus.req_wdata;
          unique case (1'b1)
            size_err(in_size, in_off): begin
              state_d = ST_ERR;
            end
            (bus.req_we && in_size == SZ_WORD): begin
              state_d = ST_WR;
              mem_a_d = bus.req_addr[ADDR_W+1:2];
              mem_w_d = 1'b1;
              mem_d_d = bus.req_wdata;
            end
            default: begin
              state_d = ST_RD;
              mem_a_d = bus.req_addr[ADDR_W+1:2];
            end
          endcase
        end
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      // mem_q now holds the word addressed during RD
      ST_CAP: begin
        if (req_q.we) begin
          state_d = ST_WR;
          mem_w_d = 1'b1;
          mem_d_d = merge_w;
        end else begin
          state_d  = ST_IDLE;
          rdata_d  = load_w;
          rvalid_d = 1'b1;
        end
      end
      ST_WR: begin
        state_d  = ST_IDLE;
        rvalid_d = 1'b1;
      end
      ST_ERR: begin
        state_d  = ST_IDLE;
        rvalid_d = 1'b1;
        rerr_d   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      mem_a_q  <= '0;
      mem_w_q  <= 1'b0;
      mem_d_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      mem_a_q  <= mem_a_d;
      mem_w_q  <= mem_w_d;
      mem_d_q  <= mem_d_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rvalid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rerr_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_w     = mem_w_q;
  assign bus.mem_d     = mem_d_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the single-port data-memory interface: address, write strobe, write data out; read data back with 1-cycle latency.
- Sits between the execute stage and the data memory.
- Accepts byte, half and word load/store requests with a valid/ready handshake.
- Memory is word-wide with no byte enables, so it performs read-modify-write for sub-word stores.
- Extracts and sign/zero-extends sub-word load data.

Parameters:
- ADDR_W, 16, word-address width of the data memory (equals shared ADDR).
- WORD_W, 32, data width (equals shared WORD); fixed at 32 for byte-lane logic.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W+2  byte address; [1:0] is byte offset, [ADDR_W+1:2] is word address.
- req_wdata  in  WORD_W  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  WORD_W  load result; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid; request rejected.
- mem_a  out  ADDR_W  memory word address.
- mem_w  out  1  memory write strobe.
- mem_d  out  WORD_W  memory write data.
- mem_q  in  WORD_W  memory read data, valid the cycle after a read address is presented with mem_w=0.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_a=0, mem_w=0, mem_d=0.
  - A reset mid-operation abandons the request. mem_w drops before the next edge, so no partial write reaches memory.
- Outputs are registered.
- mem_w=1 only in WR; in every other state the memory performs harmless reads.
- Lanes are little-endian: byte k = bits[8k+7:8k], k = req_addr[1:0].
- Request is latched on the edge where req_valid & req_ready.
- Error check at accept (macro-dependent, see Optional Feature). On error:
  - next cycle rsp_valid=1, rsp_err=1.
  - no memory access.
- States:
  - IDLE: wait for request. Go to ERR, RD (loads and sub-word stores) or WR (word store).
  - RD: mem_a=word addr, mem_w=0. Go to CAP.
  - CAP: mem_q valid.
    - Load: extract lane, extend, register into rsp_rdata, pulse rsp_valid. Go to IDLE.
    - Sub-word store: merge req_wdata low byte/half into the mem_q copy at the offset, load mem_d. Go to WR.
  - WR: mem_a=word addr, mem_d valid, mem_w=1. Pulse rsp_valid. Go to IDLE.
  - ERR: one cycle only, then IDLE.
- Latency (accept edge = cycle 0):
  - Load: rsp_valid in cycle 3.
  - Word store: rsp_valid in cycle 2.
  - Sub-word store: rsp_valid in cycle 4.
  - Error: rsp_valid in cycle 2.
- rsp_valid is high in the cycle state returns to IDLE. req_ready is also high that cycle, so a back-to-back request is accepted on that edge.
- Extension:
  - Byte load: signed replicates bit 7, else zero-fills.
  - Half load: bit 15 / zero-fill.
  - Word load: req_signed ignored.
- mem_q is sampled only in CAP. Stale Q during writes is never used.
- Address wrap: word address truncates to ADDR_W bits; no bound check.

Optional Feature:
- Macro: MAU_ALIGN_CHECK_EN.
- Defined:
  - half with odd offset, or word with offset≠0 → error response.
  - size 11 → error.
- Undefined:
  - size 11 → error still.
  - Misaligned half/word ignores offset low bits: half uses offset&2, word uses offset 0.
  - Access proceeds normally; rsp_err only for size 11.

Decomposition:
- Shared package/include (alongside ADDR, WORD, LEN): size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD and the state encoding.
- One natural combinational sub-module, mem_lane_align. Given word, offset, size and signed, it produces:
  - extracted/extended load data;
  - the merged store word (old word + new data).

Test Plan:
- Memory word 4 = 0xA1B2C3D4 (used by all scenarios). Word load at 0x10 → mem_a=4, mem_w=0 in cycle 1; rsp_valid cycle 3; rsp_rdata=0xA1B2C3D4; rsp_err=0.
- Signed byte load at 0x13 → 0xFFFFFFA1; unsigned → 0x000000A1. Signed half at 0x12 → 0xFFFFA1B2; unsigned half at 0x10 → 0x0000C3D4.
- Byte store 0x5E at 0x11 → RD then WR with mem_a=4, mem_d=0xA1B25ED4; rsp_valid cycle 4; following word load returns 0xA1B25ED4.
- Word load at 0x12 with MAU_ALIGN_CHECK_EN → rsp_err=1 cycle 2, mem_w never 1. Without the macro → rsp_rdata=0xA1B2C3D4. size=11 → error in both builds.
- rst_n low during WR of a half store → mem_w=0 immediately; memory word unchanged; req_ready=1 after release.
- req_valid held high with two word stores → second accepted in the first's rsp_valid cycle; two mem_w pulses exactly 2 cycles apart.
